// File: rtl/rom_burst_reader_if.sv
// -----------------------------------------------------------------------------
// rom_burst_reader_if
//   Command and output-stream signals of the ROM burst reader.
//   Command : start, start_addr, len, abort  (issuer -> reader)
//             busy, done                     (reader -> issuer)
//   Stream  : out_data, out_valid, out_last  (reader -> consumer)
//             out_ready                      (consumer -> reader)
//   Modports: master = the reader itself, slave = issuer/consumer side.
// -----------------------------------------------------------------------------
interface rom_burst_reader_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int LEN_W  = ADDR_W + 1
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  len;
  logic              abort;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    input  start, start_addr, len, abort, out_ready,
    output busy, done, out_data, out_valid, out_last
  );

  modport slave (
    output start, start_addr, len, abort, out_ready,
    input  busy, done, out_data, out_valid, out_last
  );
endinterface

// File: rtl/rom_burst_reader.sv
// -----------------------------------------------------------------------------
// rom_burst_reader
//   Sequencer for an external combinational lookup ROM. A burst command
//   (start address, length) walks the ROM address upward with wrap-around;
//   each ROM word is registered and streamed out on a valid/ready interface
//   with a last-beat flag. done pulses the cycle after the last beat is taken.
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : command/stream interface (master modport)
//   rom_addr  : ROM address (the internal read-address register)
//   rom_dout  : combinational ROM data for rom_addr
// -----------------------------------------------------------------------------
module rom_burst_reader #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rom_burst_reader_if.master    bus,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [DATA_W-1:0]     rom_dout
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q,     state_d;
  logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
  logic [LEN_W-1:0]  rd_cnt_q,    rd_cnt_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q,  out_last_d;
  logic              done_q,      done_d;

  logic              accept;
  logic              fetch;

  // A beat is taken by the consumer this cycle.
  assign accept = out_valid_q && bus.out_ready;
  // Words remain and the output register is empty or being emptied, so the
  // next ROM word can be captured without a bubble.
  assign fetch  = (rd_cnt_q != '0) && (!out_valid_q || bus.out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      rd_cnt_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      rd_cnt_q    <= rd_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    rd_cnt_d    = rd_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    if (bus.abort) begin
      // Cancel wins over everything; rd_addr deliberately left untouched.
      state_d     = IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      rd_cnt_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && (bus.len != '0)) begin
            state_d   = RUN;
            rd_addr_d = bus.start_addr;
            rd_cnt_d  = bus.len;
          end
        end
        RUN: begin
          if (accept && out_last_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
          end else if (fetch) begin
            out_data_d  = rom_dout;
            out_valid_d = 1'b1;
            out_last_d  = (rd_cnt_q == LEN_W'(1));
            // Natural ADDR_W-bit overflow gives the wrap to address 0.
            rd_addr_d   = rd_addr_q + 1'b1;
            rd_cnt_d    = rd_cnt_q - 1'b1;
          end else if (accept) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rom_addr      = rd_addr_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_rom_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_rom_burst_reader
//   Bench for rom_burst_reader. ROM model mem[i]=i+1. Expected beats
//   {last,data} are queued when a burst command is issued and compared when
//   the reader hands a beat over; done, stall stability and the directed
//   scenarios are checked alongside.
// -----------------------------------------------------------------------------
module tb_rom_burst_reader;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int LEN_W  = ADDR_W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rom_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout;
  logic [DATA_W-1:0] mem [8];

  initial for (int i = 0; i < 8; i++) mem[i] = DATA_W'(i + 1);
  assign rom_dout = mem[rom_addr];

  rom_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [DATA_W:0] sb_q [$];   // {last, data}

  // ---------------- ready driver ----------------
  logic ready_toggle = 1'b0;
  int   rdy_idx = 0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_toggle) begin
        bus.out_ready = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3);
        rdy_idx++;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  // ---------------- output monitor ----------------
  int              hs_cnt = 0;
  logic            last_seen = 1'b0;
  logic            prev_stall = 1'b0;
  logic [DATA_W:0] prev_beat;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W:0] exp_beat;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_seen  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (bus.done || last_seen) begin
        chk("done_pulse", 32'(bus.done), 32'(last_seen));
        chk("done_busy_excl", 32'(bus.done && bus.busy), 32'd0);
      end
      last_seen = 1'b0;
      if (prev_stall) begin
        chk("stall_beat", 32'({bus.out_last, bus.out_data}), 32'(prev_beat));
        chk("stall_addr", 32'(rom_addr), 32'(prev_addr));
      end
      prev_stall = bus.out_valid && !bus.out_ready && !bus.abort;
      prev_beat  = {bus.out_last, bus.out_data};
      prev_addr  = rom_addr;
      if (bus.out_valid && bus.out_ready && !bus.abort) begin
        hs_cnt++;
        if (sb_q.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          exp_beat = sb_q.pop_front();
          chk("beat", 32'({bus.out_last, bus.out_data}), 32'(exp_beat));
        end
        last_seen = bus.out_last;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_start(input int a, input int l, input bit push);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.start_addr = ADDR_W'(a);
    bus.len        = LEN_W'(l);
    if (push)
      for (int k = 0; k < l; k++)
        sb_q.push_back({(k == l - 1), mem[(a + k) % 8]});
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    for (t = 0; t < budget; t++) begin
      @(negedge clk);
      if (!bus.busy && !bus.out_valid && sb_q.size() == 0) break;
    end
    if (t >= budget) chk("timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_hs(input int target, input int budget);
    int t;
    for (t = 0; t < budget; t++) begin
      @(posedge clk); #1;
      if (hs_cnt >= target && bus.out_valid) break;
    end
    if (t >= budget) chk("timeout_hs", 32'd0, 32'd1);
  endtask

  logic [ADDR_W-1:0] exp_addr [4];
  int hs_base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.start_addr = '0; bus.len = '0; bus.abort = 1'b0;
    #12;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data",  32'(bus.out_data),  32'd0);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    chk("rst_done",  32'(bus.done),      32'd0);
    chk("rst_addr",  32'(rom_addr),      32'd0);
    @(negedge clk); rst_n = 1'b1;

    // 1: basic burst and latency
    drive_start(2, 3, 1'b1);
    @(negedge clk);
    chk("lat_valid_early", 32'(bus.out_valid), 32'd0);
    chk("lat_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    wait_idle(50);

    // 2: address wrap
    exp_addr = '{3'd6, 3'd7, 3'd0, 3'd1};
    drive_start(6, 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wrap_rom_addr", 32'(rom_addr), 32'(exp_addr[i]));
    end
    wait_idle(50);

    // 3: backpressure
    hs_base = hs_cnt;
    ready_toggle = 1'b1;
    drive_start(1, 3, 1'b1);
    wait_idle(100);
    ready_toggle = 1'b0;
    chk("stall_hs_count", 32'(hs_cnt - hs_base), 32'd3);

    // 4: long burst, start while busy ignored
    drive_start(0, 10, 1'b1);
    repeat (3) @(negedge clk);
    drive_start(5, 2, 1'b0);
    wait_idle(100);

    // 5: abort on beat 2, then restart, then len=0
    hs_base = hs_cnt;
    drive_start(0, 5, 1'b1);
    wait_hs(hs_base + 1, 50);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy",  32'(bus.busy),      32'd0);
    chk("abort_done",  32'(bus.done),      32'd0);
    repeat (3) @(negedge clk);
    drive_start(4, 2, 1'b1);
    wait_idle(50);
    drive_start(3, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("len0_busy", 32'(bus.busy), 32'd0);
    end

    // 6: async reset mid-burst
    hs_base = hs_cnt;
    drive_start(3, 6, 1'b1);
    wait_hs(hs_base + 2, 50);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_last",  32'(bus.out_last),  32'd0);
    chk("arst_data",  32'(bus.out_data),  32'd0);
    chk("arst_busy",  32'(bus.busy),      32'd0);
    chk("arst_addr",  32'(rom_addr),      32'd0);
    sb_q.delete();
    @(negedge clk);
    chk("arst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    drive_start(5, 3, 1'b1);
    wait_idle(50);
    chk("final_queue_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
